// File: rtl/data_mem_slave.sv
// Word-organised data RAM on a req/gnt/rvalid data port, plus a sticky done flag and result word.
// Optional macro DMEM_RANDOM_STALL_EN inserts pseudo-random, bounded grant stalls.
`timescale 1ns/1ps
module data_mem_slave #(
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int FLAG_WORD  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  done_o,
    output logic [31:0]           result_o
);

    localparam int                  IDX_W      = $clog2(MEM_WORDS);
    localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(MEM_WORDS * 4);
    localparam logic [IDX_W-1:0]    FLAG_IDX   = IDX_W'(FLAG_WORD);
    localparam logic [IDX_W-1:0]    RESULT_IDX = IDX_W'(FLAG_WORD + 1);

    logic [31:0]      mem [0:MEM_WORDS-1];

    logic             w_stall;
    logic             w_accept;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_merged;

    logic             r_rvalid;
    logic             r_err;
    logic             r_done;
    logic [31:0]      r_rdata;

    // Handshake: a transfer is accepted on a rising edge where req & gnt; its response
    // (rvalid with rdata/err) is presented for exactly one cycle, the cycle after accept.
    assign w_idx      = data_addr_i[IDX_W+1:2];
    assign w_in_range = {1'b0, data_addr_i} < BYTE_LIMIT;
    assign data_gnt_o = data_req_i & ~w_stall;
    assign w_accept   = data_req_i & data_gnt_o;

`ifdef DMEM_RANDOM_STALL_EN
    logic [7:0] r_lfsr;
    logic [1:0] r_stall_cnt;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    // Stall counter caps at 3, so a held request is granted by its fourth cycle.
    assign w_stall   = (r_lfsr[1:0] == 2'b00) && (r_stall_cnt < 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lfsr      <= 8'hA5;
            r_stall_cnt <= 2'd0;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            if (data_req_i && !data_gnt_o) begin
                r_stall_cnt <= r_stall_cnt + 2'd1;
            end else begin
                r_stall_cnt <= 2'd0;
            end
        end
    end
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_merged = mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (data_be_i[i]) begin
                w_merged[8*i +: 8] = data_wdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept && data_we_i && w_in_range) begin
            mem[w_idx] <= w_merged;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_rvalid <= w_accept;
            r_err    <= w_accept & ~w_in_range;
            if (w_accept) begin
                r_rdata <= (w_in_range && !data_we_i) ? mem[w_idx] : 32'd0;
            end
            // done looks at the merged word, so a partial write can still raise it.
            if (w_accept && data_we_i && w_in_range && (w_idx == FLAG_IDX) && (w_merged != 32'd0)) begin
                r_done <= 1'b1;
            end
        end
    end

    assign data_rvalid_o = r_rvalid;
    assign data_err_o    = r_err;
    assign data_rdata_o  = r_rdata;
    assign done_o        = r_done;
    assign result_o      = mem[RESULT_IDX];

endmodule

// File: tb/tb_data_mem_slave.sv
// Directed bench for data_mem_slave: read/write, byte enables, back-to-back, range, done flag, reset.
`timescale 1ns/1ps
module tb_data_mem_slave;

    localparam int MEM_WORDS = 1024;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        data_req_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        done_o;
    logic [31:0] result_o;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    data_mem_slave #(.MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(32), .FLAG_WORD(0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
        .done_o(done_o), .result_o(result_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        data_req_i   = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_be_i    = be;
        data_wdata_i = wdata;
    endtask

    task automatic idle();
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = 32'd0;
        data_be_i    = 4'd0;
        data_wdata_i = 32'd0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < MEM_WORDS; i++) dut.mem[i] = 32'hA000_0000 + i;
        step();
        step();
        n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", data_rvalid_o); end
        n_cmp++; if (data_err_o !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", data_err_o); end
        n_cmp++; if (data_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", data_rdata_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done_o); end
        n_cmp++; if (data_gnt_o !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_idle: got %b want 0", data_gnt_o); end
        n_cmp++; if (result_o !== 32'hA000_0001) begin n_fail++; $display("FAIL rst_result: got %h want a0000001", result_o); end
        rst_ni = 1'b1;
        step();
        n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b want 0", data_rvalid_o); end
    endtask

    task automatic test_write_read();
        drive(1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        #1;
        n_cmp++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b want 1", data_gnt_o); end
        n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_early_rvalid: got %b want 0", data_rvalid_o); end
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL wr_rvalid: got %b want 1", data_rvalid_o); end
        n_cmp++; if (data_err_o !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", data_err_o); end
        n_cmp++; if (data_rdata_o !== 32'd0) begin n_fail++; $display("FAIL wr_rdata: got %h want 0", data_rdata_o); end
        drive(1'b0, 32'h100, 4'h0, 32'd0);
        #1;
        n_cmp++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b want 1", data_gnt_o); end
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %b want 1", data_rvalid_o); end
        n_cmp++; if (data_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", data_rdata_o); end
        n_cmp++; if (data_err_o !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", data_err_o); end
        idle();
        step();
        n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b want 0", data_rvalid_o); end
        n_cmp++; if (data_rdata_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rdata_hold: got %h want deadbeef", data_rdata_o); end
    endtask

    task automatic test_byte_enable();
        dut.mem[32'h40] = 32'h1122_3344;
        drive(1'b1, 32'h100, 4'b0010, 32'h0000_AB00);
        step();
        drive(1'b0, 32'h100, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_rdata_o !== 32'h1122_AB44) begin n_fail++; $display("FAIL be_lane1: got %h want 1122ab44", data_rdata_o); end
        drive(1'b1, 32'h104, 4'b0000, 32'hFFFF_FFFF);
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL be_none_rvalid: got %b want 1", data_rvalid_o); end
        drive(1'b0, 32'h104, 4'h0, 32'd0);
        step();
        n_cmp++; if (data_rdata_o !== 32'hA000_0041) begin n_fail++; $display("FAIL be_none_data: got %h want a0000041", data_rdata_o); end
        drive(1'b0, 32'h103, 4'h0, 32'd0);
        step();
        n_cmp++; if (data_rdata_o !== 32'h1122_AB44) begin n_fail++; $display("FAIL addr_low_ignored: got %h want 1122ab44", data_rdata_o); end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int k = 0; k < 3; k++) exp_q.push_back(32'hA000_0000 + k);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'(k * 4), 4'hF, 32'hFFFF_FFFF);
            #1;
            n_cmp++; if (data_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d: got %b want 1", k, data_gnt_o); end
            step();
            exp = exp_q.pop_front();
            n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp) begin
                n_fail++; $display("FAIL b2b_resp%0d: got rvalid=%b rdata=%h want rvalid=1 rdata=%h", k, data_rvalid_o, data_rdata_o, exp);
            end
        end
        idle();
        step();
        n_cmp++; if (data_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_tail: got %b want 0", data_rvalid_o); end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF);
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL oor_wr: got rvalid=%b err=%b rdata=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o);
        end
        drive(1'b0, 32'h1000, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL oor_rd: got rvalid=%b err=%b rdata=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o);
        end
        drive(1'b0, 32'h0, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_err_o !== 1'b0 || data_rdata_o !== 32'hA000_0000) begin
            n_fail++; $display("FAIL oor_mem0_kept: got err=%b rdata=%h want 0 a0000000", data_err_o, data_rdata_o);
        end
        drive(1'b0, 32'hFFC, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_err_o !== 1'b0 || data_rdata_o !== 32'hA000_03FF) begin
            n_fail++; $display("FAIL last_word: got err=%b rdata=%h want 0 a00003ff", data_err_o, data_rdata_o);
        end
        drive(1'b0, 32'h1000, 4'hF, 32'd0);
        step();
        idle();
        step();
        n_cmp++; if (data_err_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            n_fail++; $display("FAIL err_idle: got err=%b rvalid=%b want 0 0", data_err_o, data_rvalid_o);
        end
    endtask

    task automatic test_done_result();
        drive(1'b1, 32'h4, 4'hF, 32'h0000_002A);
        step();
        n_cmp++; if (result_o !== 32'd42) begin n_fail++; $display("FAIL result: got %h want 2a", result_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b want 0", done_o); end
        drive(1'b1, 32'h0, 4'hF, 32'h0000_0001);
        #1;
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL done_before_accept: got %b want 0", done_o); end
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1 || done_o !== 1'b1) begin
            n_fail++; $display("FAIL done_set: got rvalid=%b done=%b want 1 1", data_rvalid_o, done_o);
        end
        drive(1'b1, 32'h0, 4'hF, 32'h0);
        step();
        idle();
        step();
        n_cmp++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b want 1", done_o); end
    endtask

    task automatic test_reset_midop();
        int late_rvalid;
        drive(1'b0, 32'h100, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1) begin n_fail++; $display("FAIL pre_rst_rvalid: got %b want 1", data_rvalid_o); end
        rst_ni = 1'b0;
        idle();
        #1;
        n_cmp++; if (data_rvalid_o !== 1'b0 || done_o !== 1'b0 || data_rdata_o !== 32'd0) begin
            n_fail++; $display("FAIL async_rst: got rvalid=%b done=%b rdata=%h want 0 0 0", data_rvalid_o, done_o, data_rdata_o);
        end
        step();
        step();
        rst_ni = 1'b1;
        late_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (data_rvalid_o !== 1'b0) late_rvalid++;
        end
        n_cmp++; if (late_rvalid != 0) begin n_fail++; $display("FAIL post_rst_rvalid: got %0d cycles want 0", late_rvalid); end
        drive(1'b0, 32'h4, 4'hF, 32'd0);
        step();
        n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h2A) begin
            n_fail++; $display("FAIL post_rst_read: got rvalid=%b rdata=%h want 1 2a", data_rvalid_o, data_rdata_o);
        end
        idle();
        step();
    endtask

`ifdef DMEM_RANDOM_STALL_EN
    task automatic test_random_stall();
        logic [31:0] model [0:63];
        logic [31:0] exp;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        we;
        int          w;
        int          waited;
        for (int i = 0; i < 64; i++) model[i] = 32'hA000_0040 + i;
        for (int n = 0; n < 500; n++) begin
            we = 1'($urandom_range(0, 1));
            w  = $urandom_range(0, 63);
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            drive(we, 32'(32'h100 + w * 4), be, wd);
            #1;
            waited = 0;
            while (!data_gnt_o && waited < 6) begin
                step();
                waited++;
            end
            n_cmp++; if (waited > 3 || !data_gnt_o) begin n_fail++; $display("FAIL stall_bound: got %0d waits want <=3", waited); end
            if (!we) exp_q.push_back(model[w]);
            else for (int b = 0; b < 4; b++) if (be[b]) model[w][8*b +: 8] = wd[8*b +: 8];
            step();
            if (!we) begin
                exp = exp_q.pop_front();
                n_cmp++; if (data_rvalid_o !== 1'b1 || data_rdata_o !== exp) begin
                    n_fail++; $display("FAIL rand_rd%0d: got rvalid=%b rdata=%h want 1 %h", n, data_rvalid_o, data_rdata_o, exp);
                end
            end
        end
        idle();
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifdef DMEM_RANDOM_STALL_EN
        test_random_stall();
`else
        test_write_read();
        test_byte_enable();
        test_back_to_back();
        test_out_of_range();
        test_done_result();
        test_reset_midop();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
